// File: rtl/linear_proj_pkg.sv
// Shared constants and types for the linear-projection block: matrix geometry
// and the input-BRAM loader state encoding.
package linear_proj_pkg;

  localparam int WIDTH_A           = 8;
  localparam int CHUNK_SIZE        = 4;
  localparam int NUM_CORES_A       = 2;
  localparam int INNER_DIMENSION   = 16;
  localparam int A_OUTER_DIMENSION = 16;

  localparam int IN_MAT_WORD_W  = WIDTH_A * CHUNK_SIZE * NUM_CORES_A;
  localparam int NUM_A_ELEMENTS = INNER_DIMENSION * A_OUTER_DIMENSION * WIDTH_A / IN_MAT_WORD_W;

  typedef enum logic [1:0] {
    LD_IDLE      = 2'd0,
    LD_LOAD_EVEN = 2'd1,
    LD_LOAD_ODD  = 2'd2,
    LD_FINISH    = 2'd3
  } lp_loader_state_t;

endpackage

// File: rtl/in_mat_bram_loader.sv
// Streams input-matrix words into the dual-port input BRAM: port A takes even
// addresses, port B odd ones, so each write cycle lands one word pair.
module in_mat_bram_loader
  import linear_proj_pkg::*;
#(
  parameter int DATA_WIDTH = WIDTH_A * CHUNK_SIZE * NUM_CORES_A,
  parameter int NUM_WORDS  = NUM_A_ELEMENTS,
  parameter int ADDR_WIDTH = $clog2(INNER_DIMENSION * A_OUTER_DIMENSION * WIDTH_A / DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic                  in_mat_ena,
  output logic                  in_mat_wea,
  output logic [ADDR_WIDTH-1:0] in_mat_wr_addra,
  output logic [DATA_WIDTH-1:0] in_mat_dina,
  output logic                  in_mat_enb,
  output logic                  in_mat_web,
  output logic [ADDR_WIDTH-1:0] in_mat_wr_addrb,
  output logic [DATA_WIDTH-1:0] in_mat_dinb,
  output logic                  busy,
  output logic                  done
);

  localparam int PIDX_W = ((NUM_WORDS / 2 + 1) > 1) ? $clog2(NUM_WORDS / 2 + 1) : 1;
  localparam logic [31:0] LAST_IDX = 32'(NUM_WORDS - 1);

  if (NUM_WORDS < 1 || NUM_WORDS > (1 << ADDR_WIDTH)) begin : g_bad_cfg
    $error("in_mat_bram_loader: NUM_WORDS must be in 1..2**ADDR_WIDTH");
  end

  lp_loader_state_t      state_q, state_d;
  logic [PIDX_W-1:0]     pidx_q, pidx_d;
  logic [DATA_WIDTH-1:0] even_q, even_d;
  logic                  s_ready_q, s_ready_d;
  logic                  ena_q, ena_d, enb_q, enb_d;
  logic [ADDR_WIDTH-1:0] addra_q, addra_d, addrb_q, addrb_d;
  logic [DATA_WIDTH-1:0] dina_q, dina_d, dinb_q, dinb_d;
  logic                  busy_q, busy_d, done_q, done_d;

  logic [31:0] even_idx, odd_idx;
  logic        hs;

  assign even_idx = 32'(pidx_q) << 1;
  assign odd_idx  = even_idx + 32'd1;
  // s_ready_q is registered, so the handshake never depends combinationally on s_valid
  assign hs       = s_valid && s_ready_q;

  always_comb begin
    state_d = state_q;
    pidx_d  = pidx_q;
    even_d  = even_q;
    ena_d   = 1'b0;
    enb_d   = 1'b0;
    addra_d = addra_q;
    dina_d  = dina_q;
    addrb_d = addrb_q;
    dinb_d  = dinb_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      LD_IDLE: begin
        if (start) begin
          state_d = LD_LOAD_EVEN;
          pidx_d  = '0;
          busy_d  = 1'b1;
        end
      end
      LD_LOAD_EVEN: begin
        if (hs) begin
          even_d = s_data;
          // odd-length tail: last word goes out alone on port A
          if (even_idx == LAST_IDX) begin
            ena_d   = 1'b1;
            addra_d = even_idx[ADDR_WIDTH-1:0];
            dina_d  = s_data;
            state_d = LD_FINISH;
          end else begin
            state_d = LD_LOAD_ODD;
          end
        end
      end
      LD_LOAD_ODD: begin
        if (hs) begin
          ena_d   = 1'b1;
          enb_d   = 1'b1;
          addra_d = even_idx[ADDR_WIDTH-1:0];
          dina_d  = even_q;
          addrb_d = odd_idx[ADDR_WIDTH-1:0];
          dinb_d  = s_data;
          if (odd_idx == LAST_IDX) begin
            state_d = LD_FINISH;
          end else begin
            pidx_d  = pidx_q + 1'b1;
            state_d = LD_LOAD_EVEN;
          end
        end
      end
      LD_FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = LD_IDLE;
      end
      default: state_d = LD_IDLE;
    endcase
    s_ready_d = (state_d == LD_LOAD_EVEN) || (state_d == LD_LOAD_ODD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= LD_IDLE;
      pidx_q    <= '0;
      even_q    <= '0;
      s_ready_q <= 1'b0;
      ena_q     <= 1'b0;
      enb_q     <= 1'b0;
      addra_q   <= '0;
      dina_q    <= '0;
      addrb_q   <= '0;
      dinb_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pidx_q    <= pidx_d;
      even_q    <= even_d;
      s_ready_q <= s_ready_d;
      ena_q     <= ena_d;
      enb_q     <= enb_d;
      addra_q   <= addra_d;
      dina_q    <= dina_d;
      addrb_q   <= addrb_d;
      dinb_q    <= dinb_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign s_ready         = s_ready_q;
  assign in_mat_ena      = ena_q;
  assign in_mat_wea      = ena_q;
  assign in_mat_wr_addra = addra_q;
  assign in_mat_dina     = dina_q;
  assign in_mat_enb      = enb_q;
  assign in_mat_web      = enb_q;
  assign in_mat_wr_addrb = addrb_q;
  assign in_mat_dinb     = dinb_q;
  assign busy            = busy_q;
  assign done            = done_q;

endmodule

// File: tb/tb_in_mat_bram_loader.sv
// Directed bench for in_mat_bram_loader: three instances (4, 5 and 8 words)
// share one clock; expected writes are derived from the accepted-word index.
module tb_in_mat_bram_loader;

  localparam int DW = 16;
  localparam int AW = 5;
  localparam int ND = 3;
  localparam int NW [ND] = '{4, 5, 8};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          start   [ND];
  logic          s_valid [ND];
  logic [DW-1:0] s_data  [ND];
  logic          s_ready [ND];
  logic          ena [ND], wea [ND], enb [ND], web [ND];
  logic [AW-1:0] addra [ND], addrb [ND];
  logic [DW-1:0] dina [ND], dinb [ND];
  logic          busy [ND], done [ND];

  int vec  = 0;
  int errs = 0;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    in_mat_bram_loader #(.DATA_WIDTH(DW), .NUM_WORDS(NW[g]), .ADDR_WIDTH(AW)) u_dut (
      .clk(clk), .rst(rst), .start(start[g]), .s_valid(s_valid[g]), .s_data(s_data[g]),
      .s_ready(s_ready[g]),
      .in_mat_ena(ena[g]), .in_mat_wea(wea[g]), .in_mat_wr_addra(addra[g]), .in_mat_dina(dina[g]),
      .in_mat_enb(enb[g]), .in_mat_web(web[g]), .in_mat_wr_addrb(addrb[g]), .in_mat_dinb(dinb[g]),
      .busy(busy[g]), .done(done[g])
    );
  end

  // Runs one full load on instance d. gap: random 50% s_valid gaps;
  // restart_at: pulse start again once that many words are accepted (-1 = never);
  // hold: keep s_valid high after the last word and for a few cycles after done.
  task automatic run_load(input int d, input int nw, input bit gap, input int restart_at,
                          input bit hold, input string tag);
    int acc = 0, writes = 0, edges = 0, idx = 0, base = 0;
    bit nxt, hs, seen_done = 0;
    @(negedge clk);
    start[d] = 1'b1;
    s_valid[d] = 1'b0;
    @(negedge clk);
    start[d] = 1'b0;
    vec++;
    if (busy[d] !== 1'b1 || s_ready[d] !== 1'b1) begin
      errs++;
      $display("FAIL %s_start: busy=%b s_ready=%b, want 1 1", tag, busy[d], s_ready[d]);
    end
    for (int c = 0; c < 200 && !seen_done; c++) begin
      if (acc < nw) s_valid[d] = gap ? 1'($urandom_range(0, 1)) : 1'b1;
      else          s_valid[d] = hold;
      s_data[d]  = DW'(16'hA0 + acc);
      start[d]   = (restart_at >= 0 && acc == restart_at);
      hs  = s_valid[d] && s_ready[d];
      nxt = 1'b0;
      if (hs) begin
        idx = acc;
        acc++;
        nxt = (idx % 2 == 1) || (idx == nw - 1);
      end
      @(negedge clk);
      edges++;
      vec++;
      if (ena[d] !== nxt || wea[d] !== ena[d] || web[d] !== enb[d]) begin
        errs++;
        $display("FAIL %s_strobe: ena=%b wea=%b web=%b enb=%b, want ena=wea=%b", tag,
                 ena[d], wea[d], web[d], enb[d], nxt);
      end
      if (nxt) begin
        writes++;
        base = idx - (idx % 2);
        vec++;
        if (addra[d] !== AW'(base) || dina[d] !== DW'(16'hA0 + base)) begin
          errs++;
          $display("FAIL %s_portA: addr=%0d data=%h, want addr=%0d data=%h", tag,
                   addra[d], dina[d], base, 16'hA0 + base);
        end
        vec++;
        if (idx % 2 == 1) begin
          if (enb[d] !== 1'b1 || addrb[d] !== AW'(idx) || dinb[d] !== DW'(16'hA0 + idx)) begin
            errs++;
            $display("FAIL %s_portB: en=%b addr=%0d data=%h, want en=1 addr=%0d data=%h", tag,
                     enb[d], addrb[d], dinb[d], idx, 16'hA0 + idx);
          end
        end else if (enb[d] !== 1'b0) begin
          errs++;
          $display("FAIL %s_tailB: enb=%b, want 0 on odd tail", tag, enb[d]);
        end
      end else if (enb[d] !== 1'b0) begin
        vec++;
        errs++;
        $display("FAIL %s_gapB: enb=%b outside a write", tag, enb[d]);
      end
      if (done[d] === 1'b1) seen_done = 1;
    end
    start[d] = 1'b0;
    vec++;
    if (!seen_done || writes != (nw + 1) / 2 || acc != nw || busy[d] !== 1'b0) begin
      errs++;
      $display("FAIL %s_done: done_seen=%0d writes=%0d words=%0d busy=%b, want 1 %0d %0d 0",
               tag, seen_done, writes, acc, busy[d], (nw + 1) / 2, nw);
    end
    if (!gap && restart_at < 0) begin
      vec++;
      if (edges + 1 != nw + 2) begin
        errs++;
        $display("FAIL %s_latency: %0d cycles from start to done, want %0d", tag, edges + 1, nw + 2);
      end
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vec++;
      if (done[d] !== 1'b0 || s_ready[d] !== 1'b0 || ena[d] !== 1'b0 || enb[d] !== 1'b0 ||
          busy[d] !== 1'b0) begin
        errs++;
        $display("FAIL %s_after: done=%b s_ready=%b ena=%b enb=%b busy=%b, want all 0", tag,
                 done[d], s_ready[d], ena[d], enb[d], busy[d]);
      end
    end
    s_valid[d] = 1'b0;
  endtask

  task automatic test_reset();
    for (int d = 0; d < ND; d++) begin
      vec++;
      if ({s_ready[d], ena[d], wea[d], addra[d], dina[d], enb[d], web[d], addrb[d], dinb[d],
           busy[d], done[d]} !== '0) begin
        errs++;
        $display("FAIL reset_outputs[%0d]: ena=%b addra=%0d dina=%h addrb=%0d dinb=%h busy=%b s_ready=%b, want all 0",
                 d, ena[d], addra[d], dina[d], addrb[d], dinb[d], busy[d], s_ready[d]);
      end
    end
  endtask

  task automatic test_basic4();     run_load(0, 4, 1'b0, -1, 1'b0, "basic4");    endtask
  task automatic test_odd_tail();   run_load(1, 5, 1'b0, -1, 1'b0, "odd5");      endtask
  task automatic test_gaps();       run_load(2, 8, 1'b1, -1, 1'b0, "gaps8");     endtask
  task automatic test_restart_hold(); run_load(0, 4, 1'b0, 2, 1'b1, "restart"); endtask

  task automatic test_rst_midload();
    @(negedge clk);
    start[2] = 1'b1;
    @(negedge clk);
    start[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_valid[2] = 1'b1;
      s_data[2]  = DW'(16'hA0 + i);
      @(negedge clk);
    end
    s_valid[2] = 1'b0;
    vec++;
    if (addrb[2] !== AW'(1) || busy[2] !== 1'b1) begin
      errs++;
      $display("FAIL midrst_pre: addrb=%0d busy=%b, want 1 1", addrb[2], busy[2]);
    end
    rst = 1'b1;
    #1;
    vec++;
    if ({s_ready[2], ena[2], wea[2], addra[2], dina[2], enb[2], web[2], addrb[2], dinb[2],
         busy[2], done[2]} !== '0) begin
      errs++;
      $display("FAIL midrst_outputs: s_ready=%b busy=%b addrb=%0d dinb=%h, want all 0",
               s_ready[2], busy[2], addrb[2], dinb[2]);
    end
    @(negedge clk);
    rst = 1'b0;
    run_load(2, 8, 1'b0, -1, 1'b0, "reload8");
  endtask

  initial begin
    for (int d = 0; d < ND; d++) begin
      start[d] = 1'b0;
      s_valid[d] = 1'b0;
      s_data[d] = '0;
    end
    rst = 1'b1;
    #12;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_basic4();
    test_odd_tail();
    test_gaps();
    test_restart_hold();
    test_rst_midload();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/in_mat_bram_loader.md
# in_mat_bram_loader

Streaming writer for the linear-projection input BRAM: accepts input-matrix words on a valid/ready stream and drives the dual-port write interface (`in_mat_ena/wea/wr_addra/dina`, `in_mat_enb/web/wr_addrb/dinb`) of `top_lp_bridge`. Port A always writes even word addresses and port B the odd ones, so one word pair lands per write cycle. Sits between the host/DMA stream and `top_lp_bridge`, replacing bench-driven BRAM loading; signals completion so the projection pipeline can start.

## Interface
- `DATA_WIDTH`, default `WIDTH_A*CHUNK_SIZE*NUM_CORES_A`: width of one BRAM word.
- `NUM_WORDS`, default `NUM_A_ELEMENTS`: words per matrix load, ≥1, odd allowed.
- `ADDR_WIDTH`, default `$clog2(INNER_DIMENSION*A_OUTER_DIMENSION*WIDTH_A/DATA_WIDTH)`: BRAM address width.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle request to begin a load; honoured only in IDLE.
- `s_valid`  in  1  input word valid.
- `s_data`  in  DATA_WIDTH  input word, row-major, word 0 first.
- `s_ready`  out  1  loader accepts a word this cycle.
- `in_mat_ena`, `in_mat_wea`  out  1 each  port A enable/write strobe (always equal).
- `in_mat_wr_addra`  out  ADDR_WIDTH  port A address (even).
- `in_mat_dina`  out  DATA_WIDTH  port A data.
- `in_mat_enb`, `in_mat_web`  out  1 each  port B enable/write strobe (always equal).
- `in_mat_wr_addrb`  out  ADDR_WIDTH  port B address (odd).
- `in_mat_dinb`  out  DATA_WIDTH  port B data.
- `busy`  out  1  high from accepted `start` until `done`.
- `done`  out  1  one-cycle pulse after the final write.

## Operation
- States: IDLE, LOAD_EVEN, LOAD_ODD, FINISH.
- IDLE: `s_ready=0`; `start` → LOAD_EVEN, pair index `pidx=0`, `busy=1`.
- LOAD_EVEN: `s_ready=1`; handshake (`s_valid&&s_ready`) captures word into `even_reg`. If `2*pidx == NUM_WORDS-1` (odd tail): schedule port-A-only write of `even_reg` at `2*pidx`, go FINISH; else go LOAD_ODD.
- LOAD_ODD: `s_ready=1`; handshake schedules a paired write: A ← (`2*pidx`, `even_reg`), B ← (`2*pidx+1`, `s_data`). If `2*pidx+1 == NUM_WORDS-1` go FINISH, else `pidx++`, go LOAD_EVEN.
- FINISH: `s_ready=0`; `done` pulses, `busy` falls, → IDLE.
- Odd tail: port B not enabled; no duplicate write of the last word.
- No handshake → state and `even_reg` hold; strobes low.
- `start` while not IDLE: ignored. `s_valid` in IDLE/FINISH: not accepted, no writes.
- Address arithmetic unsigned, `pidx` width `$clog2(NUM_WORDS/2+1)`; addresses truncated to ADDR_WIDTH (NUM_WORDS ≤ 2^ADDR_WIDTH, elaboration assertion).

## Timing
- Reset: all outputs 0 (`s_ready`, strobes, addresses, data, `busy`, `done`), state IDLE, `pidx=0`.
- All outputs registered. Write strobes/address/data asserted exactly 1 cycle after the completing handshake, high for 1 cycle.
- `s_ready` is a function of registered state only (no combinational path from `s_valid`).
- `busy` high cycle after `start`; `done` coincides with the cycle after the last write strobe; `busy` low same cycle as `done`.
- Peak throughput: 1 word/cycle, one write cycle per 2 words. Total load ≥ NUM_WORDS+2 cycles after `start`.
- `rst` mid-load: immediate return to reset values; partial BRAM content undefined; next `start` restarts at address 0.

## Structure
- Loader state enum typedef `lp_loader_state_t` and `NUM_A_ELEMENTS` live in `linear_proj_pkg`; width constants reused from same package.
- Single flat module; no sub-module.

## Test plan
- NUM_WORDS=4, continuous `s_valid`, words 0xA0..0xA3 → writes (A0,0xA0 / B1,0xA1) then (A2,0xA2 / B3,0xA3); `done` 1 cycle after 2nd write; total 6 cycles from `start`.
- NUM_WORDS=5 → third write has `in_mat_ena=1` addr 4 data word 4, `in_mat_enb=0`; no write to addr 4 on port B.
- Random `s_valid` gaps (50%) with NUM_WORDS=8 → identical address/data sequence, no strobes during gaps, exactly 4 write cycles.
- `start` pulsed again mid-load and `s_valid` held after `done` → no restart, no extra writes, `s_ready=0` after FINISH.
- `rst` asserted after 3 words accepted → all outputs 0 within same cycle; new `start` reloads from addr 0 correctly.
- End-to-end with `top_lp_bridge` loading `mem_A.mem` → BRAM contents match file word-for-word.
